// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// scan_decoder : registered N-to-2^N one-hot decoder with direct and scan modes
// Rev 1.0
// ============================================================================
module scan_decoder #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                E,
    input  logic                mode,
    input  logic [N-1:0]        A,
    input  logic                load,
    output logic [(1<<N)-1:0]   Y,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int c_W  = 1 << N;
    localparam int c_DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [c_W-1:0]  c_ONE        = {{(c_W-1){1'b0}}, 1'b1};
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);

    logic [N-1:0]    idx_q,   idx_d;
    logic [c_DW-1:0] dwell_q, dwell_d;
    logic [c_W-1:0]  y_q,     y_d;
    logic            wrap_q,  wrap_d;
    logic [N-1:0]    idx_inc;

    assign idx_inc = idx_q + N'(1);

    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        y_d     = y_q;
        wrap_d  = 1'b0;
        if (!E) begin
            // idx and dwell stay frozen so scanning resumes in place
            y_d = '0;
        end else if (!mode || load) begin
            idx_d   = A;
            dwell_d = '0;
            y_d     = c_ONE << A;
        end else if (dwell_q == c_DWELL_LAST) begin
            idx_d   = idx_inc;
            dwell_d = '0;
            y_d     = c_ONE << idx_inc;
            wrap_d  = (idx_q == {N{1'b1}});
        end else begin
            dwell_d = dwell_q + c_DW'(1);
            y_d     = c_ONE << idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            dwell_q <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_scan_decoder : vector table + scoreboard bench for scan_decoder
// Rev 1.0
// ============================================================================
module tb_scan_decoder;

    typedef struct packed {
        logic       rst;
        logic       e;
        logic       m;
        logic       l;
        logic [1:0] a;
        logic [3:0] y;
        logic [1:0] idx;
        logic       wrap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       E = 1'b0, mode = 1'b0, load = 1'b0;
    logic [1:0] A = 2'd0;
    logic [3:0] Y;
    logic [1:0] idx;
    logic       wrap;

    logic       e_b = 1'b1, mode_b = 1'b1, load_b = 1'b0;
    logic [0:0] a_b = 1'b0;
    logic [1:0] y_b;
    logic [0:0] idx_b;
    logic       wrap_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    vec_t sb[$];
    int   split;

    always #5 clk = ~clk;

    scan_decoder #(.N(2), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .E(E), .mode(mode), .A(A), .load(load),
        .Y(Y), .idx(idx), .wrap(wrap)
    );

    scan_decoder #(.N(1), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .E(e_b), .mode(mode_b), .A(a_b), .load(load_b),
        .Y(y_b), .idx(idx_b), .wrap(wrap_b)
    );

    function automatic void add(input logic r, input logic e, input logic m,
                                input logic l, input logic [1:0] a,
                                input logic [1:0] ei, input logic ew, input logic blank);
        vec_t v;
        v.rst = r; v.e = e; v.m = m; v.l = l; v.a = a;
        v.idx = ei; v.wrap = ew;
        v.y = blank ? 4'b0000 : (4'b0001 << ei);
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int vn, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, vn, act, exp);
        end
    endtask

    task automatic apply(input int vn);
        vec_t v, x;
        v = tbl[vn];
        @(negedge clk);
        rst = v.rst; E = v.e; mode = v.m; load = v.l; A = v.a;
        sb.push_back(v);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("Y",    vn, 32'(Y),    32'(x.y));
        chk("idx",  vn, 32'(idx),  32'(x.idx));
        chk("wrap", vn, 32'(wrap), 32'(x.wrap));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, disabled outputs, then direct decode of every address
        add(1, 0, 0, 0, 2'd0, 2'd0, 0, 1);
        add(0, 0, 0, 0, 2'd0, 2'd0, 0, 1);
        add(0, 0, 0, 0, 2'd0, 2'd0, 0, 1);
        for (int a = 0; a < 4; a++) begin
            add(0, 1, 0, 1, 2'(a), 2'(a), 0, 0);
            add(0, 1, 0, 0, 2'(a), 2'(a), 0, 0);
        end
        // scan from reset: step every 4th edge, wrap on edge 16
        add(1, 1, 1, 0, 2'd0, 2'd0, 0, 1);
        for (int k = 1; k <= 23; k++)
            add(0, 1, 1, 0, 2'd0, 2'((k / 4) % 4), (k == 16), 0);
        // preload at dwell=3 on idx=1 beats the pending step
        add(0, 1, 1, 1, 2'd3, 2'd3, 0, 0);
        for (int k = 1; k <= 4; k++)
            add(0, 1, 1, 0, 2'd0, 2'((3 + k / 4) % 4), (k == 4), 0);
        // reach idx=2, dwell=1 then freeze for 5 cycles (load ignored while off)
        for (int j = 1; j <= 9; j++)
            add(0, 1, 1, 0, 2'd0, 2'((j / 4) % 4), 0, 0);
        for (int j = 0; j < 5; j++)
            add(0, 0, 1, (j == 2), 2'd1, 2'd2, 0, 1);
        add(0, 1, 1, 0, 2'd0, 2'd2, 0, 0);
        add(0, 1, 1, 0, 2'd0, 2'd2, 0, 0);
        add(0, 1, 1, 0, 2'd0, 2'd3, 0, 0);
        add(0, 1, 1, 1, 2'd2, 2'd2, 0, 0);
        add(0, 1, 1, 0, 2'd0, 2'd2, 0, 0);
        split = tbl.size();
        // after async reset: restart at idx 0; then direct->scan handover
        for (int k = 1; k <= 4; k++)
            add(0, 1, 1, 0, 2'd0, 2'((k / 4) % 4), 0, 0);
        add(0, 1, 0, 0, 2'd1, 2'd1, 0, 0);
        for (int k = 1; k <= 4; k++)
            add(0, 1, 1, 0, 2'd0, 2'(1 + k / 4), 0, 0);

        #2;
        chk("Y_async_rst",   -1, 32'(Y),   32'd0);
        chk("y_b_async_rst", -1, 32'(y_b), 32'd0);

        for (int i = 0; i < split; i++)
            apply(i);

        // async reset between edges while Y=0100
        #2;
        rst = 1'b1;
        #1;
        chk("Y_mid_rst",    -2, 32'(Y),    32'd0);
        chk("idx_mid_rst",  -2, 32'(idx),  32'd0);
        chk("wrap_mid_rst", -2, 32'(wrap), 32'd0);

        for (int i = split; i < tbl.size(); i++)
            apply(i);

        // N=1, DWELL=1: toggle every edge, wrap on each 1->0 step
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("y_b_reset", -3, 32'(y_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk("y_b",    k, 32'(y_b),    32'(2'b01 << (k % 2)));
            chk("idx_b",  k, 32'(idx_b),  32'(k % 2));
            chk("wrap_b", k, 32'(wrap_b), 32'((k % 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
